// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and limits for the bit-serial adder
package add_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;

    modport master (
        output START, SUB, A, B,
        input  BUSY, DONE, S, Cout, OVF
    );

    modport slave (
        input  START, SUB, A, B,
        output BUSY, DONE, S, Cout, OVF
    );
endinterface

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - WIDTH-bit serial add/subtract, one bit per clock, LSB first
module serial_adder
    import add_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   s_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   sum_next;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Written as shift-then-insert so WIDTH=1 needs no special slice.
    always_comb begin
        sum_next          = sum_sr >> 1;
        sum_next[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        a_sr   <= bus.A;
                        b_sr   <= bus.SUB ? ~bus.B : bus.B;
                        carry  <= bus.SUB;
                        sum_sr <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= sum_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB cell here
                        s_q    <= sum_next;
                        cout_q <= fa_c;
                        ovf_q  <= carry ^ fa_c;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(3)) if3 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input string tag, input bit timing);
        int n;
        int busy_n;
        @(negedge clk);
        if8.A = a; if8.B = b; if8.SUB = sub; if8.START = 1'b1;
        @(negedge clk);
        if8.START = 1'b0;
        n = 0; busy_n = 0;
        while (!if8.DONE && n < 20) begin
            if (if8.BUSY) busy_n++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(if8.DONE), 32'd1);
        if (timing) begin
            check({tag, "_latency"}, 32'(n), 32'd8);
            check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
            check({tag, "_busy_at_done"}, 32'(if8.BUSY), 32'd0);
        end
        check({tag, "_s"}, 32'(if8.S), 32'(es));
        check({tag, "_cout"}, 32'(if8.Cout), 32'(ec));
        check({tag, "_ovf"}, 32'(if8.OVF), 32'(eo));
    endtask

    initial begin
        int n;
        int cyc;
        int last;
        int k;
        bit done_seen;
        logic [7:0] ba [3];
        logic [7:0] bb [3];
        logic [7:0] bs [3];
        logic       bc [3];
        logic       bo [3];

        if8.START = 0; if8.SUB = 0; if8.A = '0; if8.B = '0;
        if3.START = 0; if3.SUB = 0; if3.A = '0; if3.B = '0;

        #12;
        check("rst_s", 32'(if8.S), 32'd0);
        check("rst_cout", 32'(if8.Cout), 32'd0);
        check("rst_ovf", 32'(if8.OVF), 32'd0);
        check("rst_busy", 32'(if8.BUSY), 32'd0);
        check("rst_done", 32'(if8.DONE), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01", 1'b1);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01", 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01", 1'b0);
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07", 1'b1);
        op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01", 1'b0);

        // START pulse in the middle of a run must be dropped
        @(negedge clk);
        if8.A = 8'h0F; if8.B = 8'h01; if8.SUB = 1'b0; if8.START = 1'b1;
        @(negedge clk);
        if8.START = 1'b0;
        n = 0;
        while (!if8.DONE && n < 20) begin
            if (n == 3) begin
                if8.A = 8'h55; if8.B = 8'h22; if8.SUB = 1'b1; if8.START = 1'b1;
            end else begin
                if8.START = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if8.START = 1'b0;
        check("ign_latency", 32'(n), 32'd8);
        check("ign_s", 32'(if8.S), 32'h10);
        check("ign_cout", 32'(if8.Cout), 32'd0);
        @(negedge clk);
        check("ign_no_restart", 32'(if8.BUSY), 32'd0);

        ba = '{8'h01, 8'h12, 8'h80};
        bb = '{8'h02, 8'h34, 8'h80};
        bs = '{8'h03, 8'h46, 8'h00};
        bc = '{1'b0, 1'b0, 1'b1};
        bo = '{1'b0, 1'b0, 1'b1};
        if8.A = ba[0]; if8.B = bb[0]; if8.SUB = 1'b0; if8.START = 1'b1;
        k = 0; cyc = 0; last = 0;
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (if8.DONE) begin
                check($sformatf("b2b%0d_s", k), 32'(if8.S), 32'(bs[k]));
                check($sformatf("b2b%0d_cout", k), 32'(if8.Cout), 32'(bc[k]));
                check($sformatf("b2b%0d_ovf", k), 32'(if8.OVF), 32'(bo[k]));
                if (k > 0) check($sformatf("b2b%0d_spacing", k), 32'(cyc - last), 32'd9);
                last = cyc;
                k++;
                if (k < 3) begin
                    if8.A = ba[k]; if8.B = bb[k];
                end else begin
                    if8.START = 1'b0;
                end
            end
        end
        if8.START = 1'b0;
        check("b2b_count", 32'(k), 32'd3);

        // Abort a run with reset; previous result (00, Cout=1, OVF=1) must clear
        @(negedge clk);
        if8.A = 8'hAA; if8.B = 8'h11; if8.SUB = 1'b0; if8.START = 1'b1;
        @(negedge clk);
        if8.START = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if8.DONE) done_seen = 1;
        end
        rst_n = 1'b0;
        #1;
        check("rstmid_s", 32'(if8.S), 32'd0);
        check("rstmid_cout", 32'(if8.Cout), 32'd0);
        check("rstmid_ovf", 32'(if8.OVF), 32'd0);
        check("rstmid_busy", 32'(if8.BUSY), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.DONE || if8.BUSY) done_seen = 1;
        end
        check("rstmid_no_done", 32'(done_seen), 32'd0);
        op8(8'h3C, 8'h03, 1'b1, 8'h39, 1'b1, 1'b0, "post_rst_sub", 1'b1);

        for (int sub = 0; sub < 2; sub++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    logic [2:0] bx;
                    logic [3:0] sum;
                    logic       ov;
                    bx  = (sub != 0) ? ~3'(b) : 3'(b);
                    sum = 4'(a) + 4'(bx) + 4'(sub);
                    ov  = (a[2] == bx[2]) && (sum[2] != a[2]);
                    @(negedge clk);
                    if3.A = 3'(a); if3.B = 3'(b); if3.SUB = sub[0]; if3.START = 1'b1;
                    @(negedge clk);
                    if3.START = 1'b0;
                    n = 0;
                    while (!if3.DONE && n < 10) begin
                        @(negedge clk);
                        n++;
                    end
                    check($sformatf("w3 t=%0t sub=%0d A=%0d B=%0d S=%0d Cout=%0d",
                                    $time, sub, a, b, if3.S, if3.Cout),
                          {24'd0, if3.DONE, n[2:0], if3.S, if3.Cout, if3.OVF},
                          {24'd0, 1'b1, 3'd3, sum[2:0], sum[3], ov});
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that generalises the single-bit structural full adder into a WIDTH-bit sequential datapath. One full-adder cell plus a carry flip-flop processes one bit per clock, LSB first, under a START/BUSY/DONE handshake. The block is the first sequential arithmetic unit in the lab datapath and is driven by the same self-checking bench flow as the combinational adders.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- START  input  1  request to begin an operation; sampled only when BUSY=0.
- SUB  input  1  0 = A+B, 1 = A−B; sampled with START.
- A  input  WIDTH  operand A; sampled with START.
- B  input  WIDTH  operand B; sampled with START.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when the result is valid.
- S  output  WIDTH  result; holds its value until the next completion.
- Cout  output  1  final carry out. For subtraction, 1 = no borrow.
- OVF  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States:
  - IDLE: BUSY=0. START=1 at an edge causes the following actions:
    - Load the A shift register with A.
    - Load the B shift register with B when SUB=0, or with ~B when SUB=1.
    - Set carry FF = SUB.
    - Clear the sum shift register.
    - Set bit counter = 0.
    - Move to RUN.
  - RUN: BUSY=1. At each edge, the fa_cell operates on A_sr[0], B_sr[0] and the carry FF:
    - Shift the sum bit into the MSB of the sum register.
    - Right-shift the A and B registers.
    - Update the carry FF.
    - Increment the counter.
    - When the counter reaches WIDTH−1 (the last bit):
      - Register S = final sum vector.
      - Register Cout = fa_cell carry.
      - Register OVF = carry FF (carry into MSB) XOR fa_cell carry.
      - Pulse DONE.
      - Return to IDLE.
- START while BUSY=1 is ignored: no queueing and no error.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1. Cout and OVF follow two's-complement rules.
- WIDTH=1: RUN lasts exactly one cycle, and OVF = Cin XOR Cout of the single cell.
- Reset value of every output and internal register is 0: S=0, Cout=0, OVF=0, BUSY=0, DONE=0, state=IDLE.
- rst_n asserted mid-operation: all registers clear immediately, asynchronously. The operation in progress is abandoned and no DONE is issued. After rst_n deasserts, the block is in IDLE.

## Timing
- Edge E0 samples START=1 in IDLE. BUSY is high from E0 to EWIDTH.
- Edges E1..EWIDTH process bits 0..WIDTH−1.
- S, Cout, OVF and DONE update at EWIDTH. DONE is high for exactly one cycle.
- Latency from the START-sampling edge to DONE is WIDTH cycles.
- Back-to-back operation: START held high during the DONE cycle is sampled at EWIDTH+1 (state is IDLE), so the next operation begins with no bubble beyond DONE.
- S, Cout and OVF are stable from DONE until the next completion. They do not change while a new operation is in RUN.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package add_pkg:
  - State enum: IDLE, RUN.
  - Constant for the maximum WIDTH (32).
- Sub-module fa_cell: a purely combinational 1-bit full adder (A, B, C → S, Cout), instantiated once.
- The controller, counter, shift registers and output registers live in serial_adder. No other sub-modules.

## Test plan
- WIDTH=8, A=8'h0F, B=8'h01, SUB=0 → S=8'h10, Cout=0, OVF=0; DONE exactly 8 cycles after the START edge; BUSY high for those 8 cycles.
- WIDTH=8, A=8'hFF, B=8'h01, SUB=0 → S=8'h00, Cout=1, OVF=0. Then A=8'h7F, B=8'h01 → S=8'h80, Cout=0, OVF=1.
- WIDTH=8, SUB=1 cases:
  - A=8'h05, B=8'h07 → S=8'hFE, Cout=0 (borrow), OVF=0.
  - A=8'h80, B=8'h01 → S=8'h7F, Cout=1, OVF=1.
- START pulsed at cycle 3 of a running operation with different operands → ignored; the first result is returned unchanged.
- Back-to-back: START held high continuously → one DONE every 9 cycles, each with the correct result.
- Reset mid-operation: rst_n low at cycle 4 of RUN → S=0, Cout=0, OVF=0, BUSY=0 immediately and no DONE. A fresh operation afterwards is correct.
- Exhaustive check: WIDTH=3, SUB∈{0,1}, all 64 {A,B} pairs. Compare S, Cout and OVF with the reference model, monitoring time, A, B, S and Cout.
